mem_dm_access: RTL and testbench
================================

Name: mem_dm_access

Overview:
MEM-stage data-memory access controller, directly upstream of the load-extraction stage.
- Takes load/store requests from the EX/MEM register.
- Aligns store data and generates byte enables.
- Runs a req/ack handshake to data memory and stalls the pipeline until the access completes.
- Delivers the raw 32-bit read word plus address bits [1:0] to the extraction stage.

Parameters:
- ADDR_W, 32: byte-address width.
- WAIT_MAX, 15: maximum cycles in WAIT before timeout (used only with MEM_DM_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX/MEM holds a memory op.
- req_we  in  1  1 = store, 0 = load.
- req_full  in  1  word access (priority over half and byte).
- req_half  in  1  halfword access (priority over byte).
- req_byte  in  1  byte access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  unaligned store source (rt).
- stall  out  1  freeze PC and IF/ID/EX/MEM registers.
- align_err  out  1  misaligned access flag, combinational.
- bus_err  out  1  timeout pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word address, bits [1:0] = 0.
- mem_wdata  out  32  lane-aligned store data.
- mem_ack  in  1  memory done.
- mem_rdata  in  32  read word.
- rd_word  out  32  captured raw word to extraction stage.
- rd_addr2  out  2  req_addr[1:0] of the captured access.
- rd_valid  out  1  one-cycle pulse: rd_word valid.

Behaviour:
- Reset: every output 0; state = IDLE; counter = 0. Asserting reset mid-access drops mem_req immediately and abandons the access.
- States: IDLE, WAIT, DONE.
- Size select: full > half > byte. If none is set, the request is a no-op: stay IDLE, stall = 0.
- Misaligned access: full with addr[1:0] != 0, or half with addr[0] = 1.
  - In IDLE, align_err = 1 combinationally; no memory access; stall = 0; remain IDLE.
- IDLE with req_valid and an aligned access:
  - stall = 1.
  - Register mem_addr, mem_we, mem_be, mem_wdata and rd_addr2.
  - Next state = WAIT.
- WAIT:
  - mem_req = 1; all mem_* outputs held stable; stall = 1.
  - On mem_ack (including in the first WAIT cycle):
    - if load, rd_word <= mem_rdata;
    - rd_valid pulses in the following cycle;
    - next state = DONE.
- DONE:
  - stall = 0 and mem_req = 0, so the pipeline advances this cycle.
  - req_valid is ignored this cycle because it still refers to the completed op.
  - Next state = IDLE.
- Latency: minimum 3 cycles from IDLE issue to pipeline advance (ack in the first WAIT cycle). Each extra wait cycle adds one.
- Byte enables and store data:
  - byte: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wdata[15:0]}}.
  - full: mem_be = 4'b1111; mem_wdata = wdata.
  - load: mem_be = 4'b1111; mem_we = 0.
- Stores: rd_word is unchanged; rd_valid is not pulsed.
- A mem_ack arriving while not in WAIT is ignored.

Optional Feature:
- MEM_DM_TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If it reaches WAIT_MAX with no ack: bus_err pulses for one cycle, rd_word <= 0, mem_req drops, next state = DONE.
  - An ack arriving in the same cycle the counter reaches WAIT_MAX wins; no bus_err.
- Not defined: no counter; WAIT lasts indefinitely; bus_err is tied to 0.

Decomposition:
- Shared package:
  - state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2);
  - byte-enable constants (BE_WORD, BE_HALF_LO, BE_HALF_HI);
  - size-select priority helper.
- Sub-module mem_dm_store_align: purely combinational; (size, addr[1:0], wdata) -> (be, aligned wdata, misaligned).

Test Plan:
- Load word at 0x0000_0010, ack in first WAIT cycle, mem_rdata = 0xDEADBEEF -> mem_be = 1111, mem_addr = 0x10, stall high 2 cycles, rd_word = 0xDEADBEEF, rd_addr2 = 00, rd_valid for 1 cycle.
- Store byte wdata = 0x000000A5 at addr 0x13, ack after 3 wait cycles -> mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_we = 1, stall high 5 cycles, no rd_valid.
- Store half wdata = 0x1234 at 0x22 -> mem_be = 1100, mem_wdata = 0x12341234; half at 0x21 -> align_err = 1, mem_req never asserts, stall = 0.
- req_valid held through DONE, then a new load presented -> exactly one access per instruction; second access starts in the cycle after DONE.
- Assert rst during WAIT -> mem_req = 0 and stall = 0 immediately; after release, state = IDLE and a new load completes normally.
- With MEM_DM_TIMEOUT_EN and WAIT_MAX = 15, never ack -> bus_err pulses after 15 WAIT cycles, rd_word = 0, pipeline released next cycle.

Source files
------------

// File: rtl/mem_dm_access_pkg.sv
// Shared types for the MEM-stage data-memory access controller:
// FSM encoding, access-size select and byte-enable constants.
package mem_dm_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE    = 4'b0001;

  // Word beats half beats byte when several size flags are set.
  function automatic size_e size_sel(
    input logic full,
    input logic half,
    input logic bsel
  );
    size_e s;
    priority case (1'b1)
      full:    s = SZ_WORD;
      half:    s = SZ_HALF;
      bsel:    s = SZ_BYTE;
      default: s = SZ_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_dm_store_align.sv
// Combinational store lane alignment: byte enables, replicated
// store data and misalignment detection from size and addr[1:0].
module mem_dm_store_align
  import mem_dm_access_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = '0;
    wdata_o    = '0;
    misalign_o = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o       = addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
      end
      SZ_WORD: begin
        be_o       = BE_WORD;
        wdata_o    = wdata_i;
        misalign_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_dm_access.sv
// MEM-stage data-memory req/ack controller with pipeline stall.
// Define MEM_DM_TIMEOUT_EN to enable the WAIT timeout / bus_err.
module mem_dm_access
  import mem_dm_access_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_full,
  input  logic              req_half,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              align_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rd_word,
  output logic [1:0]        rd_addr2,
  output logic              rd_valid
);

  state_e            state_q, state_d;
  size_e             size;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              misalign;
  logic              issue;
  logic              ack_ok;
  logic              tmo;

  logic              mem_we_q;
  logic [3:0]        mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       rd_word_q;
  logic [1:0]        rd_addr2_q;
  logic              rd_valid_q;

  assign size = size_sel(req_full, req_half, req_byte);

  mem_dm_store_align u_align (
    .size_i     (size),
    .addr_i     (req_addr[1:0]),
    .wdata_i    (req_wdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .misalign_o (misalign)
  );

  assign issue  = (state_q == IDLE) && req_valid
                && (size != SZ_NONE) && !misalign;
  assign ack_ok = (state_q == WAIT) && mem_ack;

`ifdef MEM_DM_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt_q;
  logic          bus_err_q;

  // Fires on the WAIT_MAX-th WAIT cycle; a same-cycle ack wins.
  assign tmo = (state_q == WAIT) && !mem_ack
             && (cnt_q == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= tmo;
      if (issue)
        cnt_q <= '0;
      else if (state_q == WAIT)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX != 0);
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    align_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && size != SZ_NONE) begin
          if (misalign) begin
            align_err = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack || tmo)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset must release the pipeline even while req_valid is held.
    if (rst) begin
      stall     = 1'b0;
      align_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_word_q   <= '0;
      rd_addr2_q  <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= ack_ok && !mem_we_q;
      if (issue) begin
        mem_we_q    <= req_we;
        mem_be_q    <= req_we ? al_be : BE_WORD;
        mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata_q <= req_we ? al_wdata : 32'h0;
        rd_addr2_q  <= req_addr[1:0];
      end
      if (ack_ok && !mem_we_q)
        rd_word_q <= mem_rdata;
      else if (tmo)
        rd_word_q <= '0;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_word   = rd_word_q;
  assign rd_addr2  = rd_addr2_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_mem_dm_access.sv
// Randomized self-checking bench for mem_dm_access against a
// transaction-level model of lanes, latency and read capture.
module tb_mem_dm_access;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_full, req_half, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        stall, align_err, bus_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] rd_word;
  logic [1:0]  rd_addr2;
  logic        rd_valid;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int exp_acc = 0;
  logic req_prev = 1'b0;
  logic [31:0] m_rd_word = '0;

  always #5 clk = ~clk;

  mem_dm_access #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_full  (req_full),
    .req_half  (req_half),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .align_err (align_err),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rd_word   (rd_word),
    .rd_addr2  (rd_addr2),
    .rd_valid  (rd_valid)
  );

  // Count memory transactions as rising edges of mem_req.
  always @(posedge clk) begin
    if (mem_req && !req_prev) n_acc++;
    req_prev <= mem_req;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(int sz, int a, bit we);
    if (!we) return 4'hF;
    case (sz)
      1:       return 4'(1 << (a % 4));
      2:       return 4'(3 << (a & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(int sz, logic [31:0] wd);
    case (sz)
      1:       return 32'(wd[7:0]) * 32'h0101_0101;
      2:       return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic bit misal(int sz, int a);
    return (sz == 3 && (a % 4) != 0) || (sz == 2 && (a % 2) != 0);
  endfunction

  // sz: 0 none, 1 byte, 2 half, 3 word; dly < 0 means never ack.
  task automatic do_op(bit we, int sz, logic [31:0] addr,
                       logic [31:0] wd, int dly, logic [31:0] rdata);
    int  nst;
    int  w;
    bit  done;
    bit  bad;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_full  = (sz == 3);
    req_half  = (sz == 2);
    req_byte  = (sz == 1);
    req_addr  = addr;
    req_wdata = wd;
    mem_ack   = 1'b0;
    #1;
    bad = misal(sz, int'(addr[1:0]));
    if (sz == 0 || bad) begin
      chk("align_err", 32'(align_err), 32'(bad));
      chk("idle_stall", 32'(stall), 32'(0));
      @(posedge clk);
      #1;
      chk("no_req", 32'(mem_req), 32'(0));
      req_valid = 1'b0;
      return;
    end
    chk("issue_stall", 32'(stall), 32'(1));
    chk("issue_align", 32'(align_err), 32'(0));
    exp_acc++;
    nst  = 1;
    w    = 0;
    done = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        if (w == 0) begin
          chk("mem_req", 32'(mem_req), 32'(1));
          chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
          chk("mem_be", 32'(mem_be),
              32'(exp_be(sz, int'(addr[1:0]), we)));
          chk("mem_we", 32'(mem_we), 32'(we));
          if (we) chk("mem_wdata", mem_wdata, exp_wd(sz, wd));
        end
        mem_ack   = (dly >= 0 && w == dly);
        mem_rdata = mem_ack ? rdata : $urandom;
        nst++;
        w++;
      end else begin
        done = 1'b1;
        chk("done_req", 32'(mem_req), 32'(0));
        chk("stall_cyc", 32'(nst),
            32'(dly < 0 ? WAIT_MAX + 1 : dly + 2));
        chk("bus_err", 32'(bus_err), 32'(dly < 0));
        chk("rd_valid", 32'(rd_valid), 32'(!we && dly >= 0));
        if (dly < 0) m_rd_word = '0;
        else if (!we) m_rd_word = rdata;
        chk("rd_word", rd_word, m_rd_word);
        chk("rd_addr2", 32'(rd_addr2), 32'(addr[1:0]));
        mem_ack = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      chk("cycle_budget", 32'(0), 32'(1));
      rst = 1'b1;
      m_rd_word = '0;
      #1;
      rst = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));
    #1;
    chk("idle_rd_valid", 32'(rd_valid), 32'(0));
    chk("idle_stall", 32'(stall), 32'(0));
    chk("idle_req", 32'(mem_req), 32'(0));
    chk("idle_bus_err", 32'(bus_err), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_full = 0;
    req_half = 0; req_byte = 0;
    req_addr = '0; req_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_we", 32'(mem_we), 32'(0));
    chk("rst_be", 32'(mem_be), 32'(0));
    chk("rst_addr", mem_addr, 32'(0));
    chk("rst_wdata", mem_wdata, 32'(0));
    chk("rst_rd_word", rd_word, 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_bus_err", 32'(bus_err), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    do_op(0, 3, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
    idle_cyc();
    do_op(1, 1, 32'h0000_0013, 32'h0000_00A5, 3, 32'h0);
    idle_cyc();
    do_op(1, 2, 32'h0000_0022, 32'h0000_1234, 1, 32'h0);
    do_op(1, 2, 32'h0000_0021, 32'h0000_1234, 0, 32'h0);
    do_op(0, 0, 32'h0000_0040, 32'h0, 0, 32'h0);
    // Back-to-back: req_valid stays high through DONE into next op.
    do_op(0, 3, 32'h0000_0100, 32'h0, 0, 32'h1111_2222);
    do_op(0, 2, 32'h0000_0106, 32'h0, 2, 32'h3333_4444);
    idle_cyc();

    // Reset in the middle of WAIT abandons the access.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_full = 1;
    req_half = 0; req_byte = 0;
    req_addr = 32'h0000_0200; mem_ack = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_req", 32'(mem_req), 32'(0));
    chk("rstw_stall", 32'(stall), 32'(0));
    chk("rstw_rd_word", rd_word, 32'(0));
    exp_acc++;
    m_rd_word = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    idle_cyc();
    do_op(0, 3, 32'h0000_0204, 32'h0, 1, 32'hCAFE_F00D);
    idle_cyc();

`ifdef MEM_DM_TIMEOUT_EN
    do_op(0, 3, 32'h0000_0300, 32'h0, -1, 32'h0);
    idle_cyc();
`endif

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom;
      do_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), a,
            $urandom, $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cyc();
    end
    idle_cyc();
    chk("access_count", 32'(n_acc), 32'(exp_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
